// File: rtl/ram_dp_1w1r_init.sv
// Simple dual-port RAM (1W/1R, one clock) that clears every word to INIT_VALUE after reset.
// Define RAM_BYPASS_EN for write-first forwarding on same-address collisions (read-first otherwise).
module ram_dp_1w1r_init #(
  parameter int unsigned            DATA_WIDTH = 4,
  parameter int unsigned            ADDR_WIDTH = 3,
  parameter logic [DATA_WIDTH-1:0]  INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  drop
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {CLEAR, READY} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    drop_q, drop_d;

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      CLEAR: begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == '1) state_d = READY;
      end
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    mem_we     = 1'b0;
    mem_waddr  = wr_addr;
    mem_wdata  = wr_data;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    drop_d     = 1'b0;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_addr_q;
        mem_wdata = INIT_VALUE;
        drop_d    = wr_en | rd_en;
      end
      READY: begin
        mem_we = wr_en;
        if (rd_en) begin
          rd_valid_d = 1'b1;
          rd_data_d  = mem_q[rd_addr];
`ifdef RAM_BYPASS_EN
          if (wr_en && (wr_addr == rd_addr)) rd_data_d = wr_data;
`endif
        end
      end
      default: ;
    endcase
  end

  // Array has no reset: the clear sequence is what initialises it.
  always_ff @(posedge clk) begin
    if (reset_L && mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      drop_q     <= drop_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign drop     = drop_q;
  assign busy     = (state_q == CLEAR);

endmodule

// File: tb/tb_ram_dp_1w1r_init.sv
// Directed self-checking bench for ram_dp_1w1r_init (4-bit words, 8 deep, INIT_VALUE 4'hA).
module tb_ram_dp_1w1r_init;

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic       rd_en = 1'b0;
  logic [2:0] rd_addr = '0;
  logic [3:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       drop;

  int unsigned tests = 0;
  int unsigned fails = 0;

`ifdef RAM_BYPASS_EN
  localparam logic [3:0] COLL_EXP = 4'h7;
`else
  localparam logic [3:0] COLL_EXP = 4'h3;
`endif

  ram_dp_1w1r_init #(
    .DATA_WIDTH (4),
    .ADDR_WIDTH (3),
    .INIT_VALUE (4'hA)
  ) dut (
    .clk      (clk),
    .reset_L  (reset_L),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .busy     (busy),
    .drop     (drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [2:0] wa;
    logic [3:0] wd;
    logic       re;
    logic [2:0] ra;
    logic       ev;
    logic [3:0] ed;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic we, input logic [2:0] wa, input logic [3:0] wd,
                     input logic re, input logic [2:0] ra, input logic ev, input logic [3:0] ed);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra; v.ev = ev; v.ed = ed;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; rd_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
  endtask

  // Releases reset and walks the 8 clear edges, checking busy after each.
  task automatic run_clear(input string tag);
    reset_L = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk({tag, "_busy"}, {3'b0, busy}, {3'b0, k < 8});
    end
  endtask

  task automatic read_all_init(input string tag);
    for (int a = 0; a < 8; a++) begin
      rd_en = 1'b1; rd_addr = 3'(a);
      step();
      chk({tag, "_valid"}, {3'b0, rd_valid}, 4'h1);
      chk({tag, "_data"}, rd_data, 4'hA);
    end
    rd_en = 1'b0;
  endtask

  initial begin
    // Reset state
    step(); step();
    chk("rst_busy", {3'b0, busy}, 4'h1);
    chk("rst_valid", {3'b0, rd_valid}, 4'h0);
    chk("rst_drop", {3'b0, drop}, 4'h0);
    chk("rst_data", rd_data, 4'h0);
    run_clear("clr1");

    // Table: initial reads, fills, read-back, collision, hold
    for (int i = 0; i < 8; i++) add(0, 0, 0, 1, 3'(i), 1, 4'hA);
    for (int i = 0; i < 8; i++) add(1, 3'(i), 4'(15 - i), 0, 0, 0, 4'hA);
    for (int i = 0; i < 8; i++) add(0, 0, 0, 1, 3'(i), 1, 4'(15 - i));
    add(1, 3'd0, 4'h1, 1, 3'd1, 1, 4'hE);
    add(0, 0, 0, 1, 3'd0, 1, 4'h1);
    add(1, 3'd2, 4'h3, 0, 0, 0, 4'h1);
    add(1, 3'd2, 4'h7, 1, 3'd2, 1, COLL_EXP);
    add(0, 0, 0, 1, 3'd2, 1, 4'h7);
    add(1, 3'd4, 4'h5, 0, 0, 0, 4'h7);
    add(0, 0, 0, 1, 3'd4, 1, 4'h5);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 3'd4, 0, 4'h5);

    foreach (vecs[i]) begin
      wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      rd_en = vecs[i].re; rd_addr = vecs[i].ra;
      step();
      chk($sformatf("vec%0d_valid", i), {3'b0, rd_valid}, {3'b0, vecs[i].ev});
      chk($sformatf("vec%0d_data", i), rd_data, vecs[i].ed);
      chk($sformatf("vec%0d_drop", i), {3'b0, drop}, 4'h0);
    end
    idle_inputs();

    // Requests during clear are dropped
    reset_L = 1'b0;
    step();
    chk("rst2_data", rd_data, 4'h0);
    reset_L = 1'b1;
    step(); step();
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'h1; rd_en = 1'b1; rd_addr = 3'd0;
    step();
    chk("drop_pulse", {3'b0, drop}, 4'h1);
    chk("drop_valid", {3'b0, rd_valid}, 4'h0);
    chk("drop_busy", {3'b0, busy}, 4'h1);
    idle_inputs();
    step();
    chk("drop_end", {3'b0, drop}, 4'h0);
    chk("drop_valid2", {3'b0, rd_valid}, 4'h0);
    for (int k = 5; k <= 8; k++) step();
    chk("drop_ready", {3'b0, busy}, 4'h0);
    read_all_init("afterdrop");

    // Reset mid-READY and again mid-CLEAR
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 4'h9;
    step();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 3'd3;
    step();
    chk("pre_rst_data", rd_data, 4'h9);
    idle_inputs();
    reset_L = 1'b0;
    step();
    chk("rst3_data", rd_data, 4'h0);
    chk("rst3_busy", {3'b0, busy}, 4'h1);
    reset_L = 1'b1;
    for (int k = 1; k <= 5; k++) step();
    reset_L = 1'b0;
    step();
    chk("rst4_busy", {3'b0, busy}, 4'h1);
    run_clear("clr4");
    read_all_init("afterrst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_dp_1w1r_init.md
# ram_dp_1w1r_init

Parametrised simple dual-port RAM (one write port, one read port, single clock) that supersedes the single-port enable/read-not-write RAM in the memory subsystem. After every reset it runs a self-clear sequence that writes `INIT_VALUE` to every word, so no location is ever read uninitialised. Reads are registered and qualified by a valid strobe. Accesses attempted during the clear are rejected and flagged.

## Interface
- `DATA_WIDTH`, default 4: word width in bits.
- `ADDR_WIDTH`, default 3: address width; DEPTH = 2^ADDR_WIDTH words.
- `INIT_VALUE`, default 0: DATA_WIDTH-bit value written to every word by the clear sequence.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset_L`  in  1  synchronous, active-low reset.
- `wr_en`  in  1  write request, sampled at the rising edge.
- `wr_addr`  in  ADDR_WIDTH  write address.
- `wr_data`  in  DATA_WIDTH  write data.
- `rd_en`  in  1  read request, sampled at the rising edge.
- `rd_addr`  in  ADDR_WIDTH  read address.
- `rd_data`  out  DATA_WIDTH  registered read data.
- `rd_valid`  out  1  one-cycle strobe: `rd_data` was updated by an accepted read.
- `busy`  out  1  high while the clear sequence runs; requests are ignored.
- `drop`  out  1  one-cycle pulse: a request arrived while `busy` was high.

## Operation
- FSM has two states, CLEAR and READY. An internal clear counter `clr_addr` is ADDR_WIDTH bits wide.
- Reset (edge with `reset_L`=0):
  - state := CLEAR; `clr_addr` := 0.
  - Outputs: `busy`=1, `rd_data`=0, `rd_valid`=0, `drop`=0.
  - Memory array is not modified during reset.
- CLEAR:
  - Each edge with `reset_L`=1 writes `INIT_VALUE` to mem[`clr_addr`] and increments `clr_addr`.
  - The edge that writes address DEPTH-1 moves the FSM to READY and sets `busy`=0.
  - `wr_en` and `rd_en` are ignored. Memory and `rd_data` are unchanged by the request.
  - `drop` is 1 on the following cycle if `wr_en` or `rd_en` was high at that edge.
- READY:
  - `wr_en`=1: mem[`wr_addr`] := `wr_data`.
  - `rd_en`=1: `rd_data` := mem[`rd_addr`] and `rd_valid` := 1. Otherwise `rd_valid` := 0 and `rd_data` holds its last value.
  - Read and write on the same edge to different addresses are independent.
  - Same-address collision (`rd_en`=`wr_en`=1, `rd_addr`=`wr_addr`): the result depends on `RAM_BYPASS_EN` (see Configuration). The write always completes.
  - `drop` stays 0.
- Reset asserted mid-CLEAR or mid-READY aborts immediately and restarts the clear from address 0. Writes completed before reset are overwritten only by the new clear.

## Timing
- Clear duration: `busy` stays high for exactly DEPTH cycles after the first edge with `reset_L`=1. It is low after edge number DEPTH.
- The first request accepted is the one sampled at edge DEPTH+1.
- Read latency is 1 cycle: address sampled at edge N; `rd_data` and `rd_valid` are valid after edge N and until edge N+1.
- Write latency is 0: data written at edge N is visible to a read sampled at edge N+1. Same-edge visibility follows `RAM_BYPASS_EN`.
- `drop` is registered and asserted in the cycle after the offending edge.
- Back-to-back reads every cycle are supported; `rd_valid` stays high continuously.

## Configuration
- Macro: `RAM_BYPASS_EN`.
- Defined: on a same-address collision, `rd_data` := `wr_data` (write-first forwarding).
- Undefined: on a same-address collision, `rd_data` := the old memory contents (read-first).
- Either way, the memory holds `wr_data` after that edge.

## Test plan
All scenarios use DATA_WIDTH=4, ADDR_WIDTH=3, INIT_VALUE=4'hA.
- Reset then release: `busy`=1 for 8 cycles, then 0. Reading addresses 0–7 returns 4'hA on each, with `rd_valid` high for one cycle per read.
- Write 15-i to address i for i=0..7, then read addresses 0..7: `rd_data` is F,E,D,C,B,A,9,8, each one cycle after its address is presented.
- Pulse `wr_en` and `rd_en` during cycle 3 of the clear: `drop`=1 for one cycle; memory ends all 4'hA; `rd_valid` stays 0.
- Address 2 holds 4'h3; write 4'h7 and read address 2 on the same edge. With `RAM_BYPASS_EN`, `rd_data`=7; without it, `rd_data`=3. A following read of address 2 returns 7 in both builds.
- Assert `reset_L`=0 for one cycle at clear cycle 5, after writes completed in READY. The clear restarts, `busy` is high for 8 more cycles, and all words read back 4'hA.
- Hold `rd_en` low for 3 cycles after a read returning 4'h5: `rd_data` holds 5 and `rd_valid`=0.
